xi_est_cal: RTL

Parametrised SOML symbol-estimate unit. Per symbol it accumulates a stream of numerator trace terms (Re tr(Y·(H·A)^H) contributions) and denominator energy terms (‖H‖² contributions), then divides the two in fixed point to produce one estimate x̂ per symbol. It generalises the single-symbol xI path to NUM_SYM symbols per block, TERMS terms per trace, and arbitrary Q-format width. It adds valid/ready handshakes, backpressure, and divide-by-zero and overflow saturation. It sits between the Hq·A / Y·GA product stage and the SOML slicer.

---
 rtl/xi_est_cal_pkg.sv | 31 +++
 rtl/qdiv_seq.sv | 68 ++++++
 rtl/xi_est_cal.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/xi_est_cal_pkg.sv
// SOML estimate shared types and helpers.
// Q-format saturation constants and state encoding.
package xi_est_cal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIVIDE,
    OUTPUT
  } state_t;

  function automatic int aw_f(
    input int n,
    input int terms
  );
    return n + $clog2(terms);
  endfunction

  function automatic longint unsigned smax_f(
    input int n
  );
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic longint unsigned smin_f(
    input int n
  );
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/qdiv_seq.sv
// Unsigned restoring divider, one quotient bit per cycle.
// First step is taken on the start edge itself.
module qdiv_seq #(
  parameter int W_DIVIDEND = 26,
  parameter int W_DIVISOR  = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W_DIVIDEND-1:0] dividend,
  input  logic [W_DIVISOR-1:0]  divisor,
  output logic                  done,
  output logic [W_DIVIDEND-1:0] quotient
);

  localparam int CW = $clog2(W_DIVIDEND + 1);

  logic [W_DIVISOR-1:0]  rem_q;
  logic [W_DIVIDEND-1:0] quo_q;
  logic [CW-1:0]         cnt_q;
  logic                  done_q;

  logic [W_DIVISOR-1:0]  rem_in;
  logic [W_DIVIDEND-1:0] quo_in;
  logic [W_DIVISOR:0]    trial;
  logic [W_DIVISOR:0]    diff;
  logic                  fits;
  logic [W_DIVISOR-1:0]  rem_nx;
  logic [W_DIVIDEND-1:0] quo_nx;

  // one restoring step on either fresh operands or the running state
  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    trial  = {rem_in, quo_in[W_DIVIDEND-1]};
    diff   = trial - {1'b0, divisor};
    fits   = trial >= {1'b0, divisor};
    rem_nx = fits ? diff[W_DIVISOR-1:0]
                  : trial[W_DIVISOR-1:0];
    quo_nx = {quo_in[W_DIVIDEND-2:0], fits};
  end

  // iterate until all dividend bits are consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      cnt_q  <= CW'(W_DIVIDEND - 1);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      cnt_q  <= cnt_q - CW'(1);
      done_q <= (cnt_q == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/xi_est_cal.sv
// SOML symbol estimate: accumulate trace terms, divide.
// Saturates on den <= 0 and on quotient overflow.
module xi_est_cal
  import xi_est_cal_pkg::*;
#(
  parameter int N       = 16,
  parameter int Q       = 8,
  parameter int TERMS   = 8,
  parameter int NUM_SYM = 4,
  localparam int SW =
    (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_num,
  input  logic [N-1:0]  in_den,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_x,
  output logic [SW-1:0] out_idx,
  output logic          out_ovf,
  output logic          busy,
  output logic          done
);

  localparam int AW = aw_f(N, TERMS);
  localparam int DW = AW + Q;
  localparam int TW = $clog2(TERMS);
  localparam int XW = AW - N;
  localparam logic [N-1:0] SMAX =
    N'(smax_f(N));
  localparam logic [N-1:0] SMIN =
    N'(smin_f(N));

  state_t state_q;
  state_t state_d;

  logic signed [AW-1:0] num_acc;
  logic signed [AW-1:0] den_acc;
  logic signed [AW-1:0] num_nx;
  logic signed [AW-1:0] den_nx;
  logic [TW-1:0]        term_cnt;
  logic [SW-1:0]        sym_idx;
  logic [N-1:0]         x_q;
  logic                 ovf_q;
  logic                 done_q;

  logic          hs_in;
  logic          hs_out;
  logic          go;
  logic          next_sym;
  logic          last_term;
  logic          last_sym;
  logic          div_start;
  logic          div_done;
  logic [AW-1:0] num_mag;
  logic [DW-1:0] dividend;
  logic [DW-1:0] quo;
  logic          den_ok;
  logic          neg;
  logic          big;
  logic          sat;
  logic [N-1:0]  x_d;
  logic          ovf_d;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUTPUT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_x     = x_q;
  assign out_ovf   = ovf_q;
  assign out_idx   = sym_idx;

  assign hs_in     = in_valid & in_ready;
  assign hs_out    = out_valid & out_ready;
  assign last_term = (term_cnt == TW'(TERMS - 1));
  assign last_sym  = (sym_idx == SW'(NUM_SYM - 1));
  assign go        = (state_q == IDLE) & start
                   & ~done_q;
  assign next_sym  = hs_out & ~last_sym;
  assign div_start = hs_in & last_term;

  // running sums including the term accepted this cycle
  always_comb begin
    num_nx = num_acc;
    den_nx = den_acc;
    if (hs_in) begin
      num_nx = num_acc
             + {{XW{in_num[N-1]}}, in_num};
      den_nx = den_acc
             + {{XW{in_den[N-1]}}, in_den};
    end
    num_mag  = num_nx[AW-1] ? -num_nx : num_nx;
    dividend = {num_mag, {Q{1'b0}}};
  end

  qdiv_seq #(
    .W_DIVIDEND(DW),
    .W_DIVISOR (AW)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend(dividend),
    .divisor (den_nx),
    .done    (div_done),
    .quotient(quo)
  );

  // sign restore and saturation of the finished quotient
  always_comb begin
    den_ok = ~den_acc[AW-1] & (den_acc != '0);
    neg    = num_acc[AW-1];
    big    = quo > {{(DW-N){1'b0}}, SMAX};
    sat    = ~den_ok | big;
    x_d    = SMAX;
    ovf_d  = 1'b1;
    unique case (1'b1)
      sat: begin
        x_d   = neg ? SMIN : SMAX;
        ovf_d = 1'b1;
      end
      !sat: begin
        x_d   = neg ? (N'(0) - quo[N-1:0])
                    : quo[N-1:0];
        ovf_d = 1'b0;
      end
    endcase
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (go) state_d = ACCUM;
      ACCUM:
        if (div_start) state_d = DIVIDE;
      DIVIDE:
        if (div_done) state_d = OUTPUT;
      OUTPUT:
        if (hs_out)
          state_d = last_sym ? IDLE : ACCUM;
      default:
        state_d = IDLE;
    endcase
  end

  // state register and end-of-block pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= hs_out & last_sym;
    end
  end

  // accumulators, term counter and symbol index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_acc  <= '0;
      den_acc  <= '0;
      term_cnt <= '0;
      sym_idx  <= '0;
    end else if (go | next_sym) begin
      num_acc  <= '0;
      den_acc  <= '0;
      term_cnt <= '0;
      sym_idx  <= go ? '0 : sym_idx + SW'(1);
    end else if (hs_in) begin
      num_acc  <= num_nx;
      den_acc  <= den_nx;
      term_cnt <= term_cnt + TW'(1);
    end
  end

  // capture the estimate as the divider finishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      ovf_q <= 1'b0;
    end else if ((state_q == DIVIDE) & div_done) begin
      x_q   <= x_d;
      ovf_q <= ovf_d;
    end
  end

endmodule
